// File: rtl/gfx_vram_dma.sv
// CPU-to-VRAM write engine: queued CPU writes plus a strided hardware fill, committed only in free bus cycles.
// Optional fill-complete flag on o_done_b is enabled by defining GFX_VRAM_DMA_DONE_IRQ_EN.
module gfx_vram_dma #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_b,
    input  logic        i_ctrl_ce_b,
    input  logic        i_ctrl_re_b,
    input  logic        i_ctrl_we_b,
    input  logic [2:0]  i_ctrl_addr,
    inout  wire  [7:0]  io_ctrl_data,
    input  logic        i_free_vbus,
    output logic [15:0] o_vaddr,
    output logic [7:0]  o_vdata,
    output logic        o_vbus_oe_b,
    output logic        o_vwe_b,
    output logic        o_done_b
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FILL = 2'd2} state_t;
    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] we_sync;
    logic        we_prev, wr_evt;
    logic [7:0]  din, rdata, status;
    logic [15:0] addr, cnt;
    logic [7:0]  step, fill_val;
    logic        overflow;
    logic        stage_valid, retire;
    logic [23:0] fifo_mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic        empty, full, push_req, push_ok, pop;
    logic        cfg_ok, go_ok, fill_load, fill_done;
    logic        wr_addr_lo, wr_addr_hi, wr_step, wr_cnt_lo, wr_cnt_hi, wr_go, wr_status;

    assign din = io_ctrl_data;

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            we_sync <= '1;
            we_prev <= 1'b1;
        end else begin
            we_sync[0] <= i_ctrl_we_b;
            for (int i = 1; i < SYNC_STAGES; i++) we_sync[i] <= we_sync[i-1];
            we_prev <= we_sync[SYNC_STAGES-1];
        end
    end

    assign wr_evt     = we_prev & ~we_sync[SYNC_STAGES-1] & ~i_ctrl_ce_b;
    assign cfg_ok     = (state != FILL);
    assign wr_addr_lo = wr_evt & (i_ctrl_addr == 3'd0) & cfg_ok;
    assign wr_addr_hi = wr_evt & (i_ctrl_addr == 3'd1) & cfg_ok;
    assign push_req   = wr_evt & (i_ctrl_addr == 3'd2);
    assign wr_step    = wr_evt & (i_ctrl_addr == 3'd3) & cfg_ok;
    assign wr_cnt_lo  = wr_evt & (i_ctrl_addr == 3'd4) & cfg_ok;
    assign wr_cnt_hi  = wr_evt & (i_ctrl_addr == 3'd5) & cfg_ok;
    assign wr_go      = wr_evt & (i_ctrl_addr == 3'd6) & cfg_ok;
    assign wr_status  = wr_evt & (i_ctrl_addr == 3'd7);

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign retire  = stage_valid & i_free_vbus;
    // The stage is only refilled in a free cycle, where it is either empty or retiring;
    // entries therefore stay in the FIFO (and count toward full) while the bus is owned by the generator.
    assign pop       = (state == DRAIN) & ~empty & i_free_vbus;
    assign push_ok   = push_req & (~full | pop);
    // A DATA push and a fill load never share an edge, so ADDR advances once per edge.
    assign fill_load = (state == FILL) & (cnt != 16'd0) & i_free_vbus & ~push_ok;
    assign fill_done = (state == FILL) & (cnt == 16'd0) & (~stage_valid | retire);
    assign go_ok     = wr_go & (cnt != 16'd0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go_ok) state_nx = FILL;
                     else if (!empty) state_nx = DRAIN;
            DRAIN:   if (go_ok) state_nx = FILL;
                     else if (empty && (!stage_valid || retire)) state_nx = IDLE;
            FILL:    if (fill_done) state_nx = (empty && !push_ok) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state       <= IDLE;
            addr        <= 16'h0000;
            step        <= 8'h01;
            cnt         <= 16'h0000;
            fill_val    <= 8'h00;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            stage_valid <= 1'b0;
            o_vaddr     <= 16'h0000;
            o_vdata     <= 8'h00;
        end else begin
            state <= state_nx;
            if (wr_addr_lo) addr[7:0]  <= din;
            if (wr_addr_hi) addr[15:8] <= din;
            if (push_ok || fill_load) addr <= addr + {8'h00, step};
            if (wr_step) step <= din;
            if (wr_cnt_lo) cnt[7:0]  <= din;
            if (wr_cnt_hi) cnt[15:8] <= din;
            if (fill_load) cnt <= cnt - 16'd1;
            if (go_ok) fill_val <= din;
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (wr_status) overflow <= 1'b0;
            if (push_ok) wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
            if (pop) rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
            if (fill_load) begin
                stage_valid <= 1'b1;
                o_vaddr     <= addr;
                o_vdata     <= fill_val;
            end else if (pop) begin
                stage_valid       <= 1'b1;
                {o_vaddr, o_vdata} <= fifo_mem[rd_ptr[PW-1:0]];
            end else if (retire) begin
                stage_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) fifo_mem[wr_ptr[PW-1:0]] <= {addr, din};
    end

    assign o_vbus_oe_b = ~(stage_valid & i_free_vbus);
    assign o_vwe_b     = ~(stage_valid & i_free_vbus & ~i_clk);

`ifdef GFX_VRAM_DMA_DONE_IRQ_EN
    logic done;
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b)       done <= 1'b0;
        else if (fill_done) done <= 1'b1;
        else if (wr_status) done <= 1'b0;
    end
    assign o_done_b = ~done;
`else
    assign o_done_b = 1'b1;
`endif

    assign status = {4'b0000, overflow, (state != IDLE) | stage_valid, full, empty};

    always_comb begin
        rdata = 8'h00;
        case (i_ctrl_addr)
            3'd0:    rdata = addr[7:0];
            3'd1:    rdata = addr[15:8];
            3'd3:    rdata = step;
            3'd4:    rdata = cnt[7:0];
            3'd5:    rdata = cnt[15:8];
            3'd7:    rdata = status;
            default: rdata = 8'h00;
        endcase
    end

    assign io_ctrl_data = (!i_ctrl_ce_b && !i_ctrl_re_b && i_ctrl_we_b) ? rdata : 8'hzz;
endmodule
